// File: rtl/breath_pkg.sv
// Shared definitions for the multi-channel LED breathing generator:
// channel state encoding, default build constants and a small width helper.
package breath_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RISE = 2'd1,
    HOLD = 2'd2,
    FALL = 2'd3
  } state_e;

  localparam int NCH_DEF      = 4;
  localparam int DW_DEF       = 4;
  localparam int MAX_DUTY_DEF = 10;
  localparam int STEP_W_DEF   = 10;
  localparam int HOLD_W_DEF   = 12;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/breath_chan.sv
// One breathing channel: start edge detect, IDLE/RISE/HOLD/FALL sequencer,
// step/hold down-counter and duty register; outputs change on the sampling edge.
module breath_chan
  import breath_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int MAX_DUTY = MAX_DUTY_DEF,
  parameter int STEP_W   = STEP_W_DEF,
  parameter int HOLD_W   = HOLD_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              loop_mode_i,
  input  logic [STEP_W-1:0] step_len_i,
  input  logic [HOLD_W-1:0] hold_len_i,
  output logic [DW-1:0]     duty_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int TW = max_int(STEP_W, HOLD_W);
  localparam logic [DW-1:0] PEAK = DW'(MAX_DUTY);

  state_e        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [DW-1:0] duty_q, duty_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          start_r_q;

  logic          rise_w, tick_w;
  logic [TW-1:0] step_ext, hold_ext, step_rl, hold_rl;
  logic [DW-1:0] duty_inc, duty_dec;

  assign rise_w   = start_i & ~start_r_q;
  assign tick_w   = (state_q != IDLE) && (tmr_q == '0);
  assign step_ext = TW'(step_len_i);
  assign hold_ext = TW'(hold_len_i);
  // A zero length behaves as one cycle, so the reload value saturates at 0.
  assign step_rl  = (step_ext == '0) ? '0 : step_ext - TW'(1);
  assign hold_rl  = (hold_ext == '0) ? '0 : hold_ext - TW'(1);
  assign duty_inc = duty_q + DW'(1);
  assign duty_dec = duty_q - DW'(1);

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    duty_d  = duty_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (stop_i) begin
      state_d = IDLE;
      tmr_d   = '0;
      duty_d  = '0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise_w) begin
            state_d = RISE;
            busy_d  = 1'b1;
            tmr_d   = step_rl;
          end
        end
        RISE: begin
          if (tick_w) begin
            duty_d = duty_inc;
            tmr_d  = step_rl;
            if (duty_inc == PEAK) begin
              state_d = HOLD;
              tmr_d   = hold_rl;
            end
          end else begin
            tmr_d = tmr_q - TW'(1);
          end
        end
        HOLD: begin
          if (tick_w) begin
            state_d = FALL;
            tmr_d   = step_rl;
          end else begin
            tmr_d = tmr_q - TW'(1);
          end
        end
        FALL: begin
          if (tick_w) begin
            duty_d = duty_dec;
            tmr_d  = step_rl;
            if (duty_dec == '0) begin
              if (loop_mode_i) begin
                state_d = RISE;
              end else begin
                state_d = IDLE;
                tmr_d   = '0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
              end
            end
          end else begin
            tmr_d = tmr_q - TW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      tmr_q     <= '0;
      duty_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      start_r_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      duty_q    <= duty_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      start_r_q <= start_i;
    end
  end

  assign duty_o = duty_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: rtl/breath_ramp_multi.sv
// NCH independent breathing channels sharing one free-running PWM counter.
// Define BREATH_PWM_EN to build the counter and registered compare; otherwise pwm is held low.
module breath_ramp_multi
  import breath_pkg::*;
#(
  parameter int NCH      = NCH_DEF,
  parameter int DW       = DW_DEF,
  parameter int MAX_DUTY = MAX_DUTY_DEF,
  parameter int STEP_W   = STEP_W_DEF,
  parameter int HOLD_W   = HOLD_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    start,
  input  logic [NCH-1:0]    stop,
  input  logic              loop_mode,
  input  logic [STEP_W-1:0] step_len,
  input  logic [HOLD_W-1:0] hold_len,
  output logic [NCH*DW-1:0] duty,
  output logic [NCH-1:0]    busy,
  output logic [NCH-1:0]    done,
  output logic [NCH-1:0]    pwm
);

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    breath_chan #(
      .DW       (DW),
      .MAX_DUTY (MAX_DUTY),
      .STEP_W   (STEP_W),
      .HOLD_W   (HOLD_W)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .start_i     (start[g]),
      .stop_i      (stop[g]),
      .loop_mode_i (loop_mode),
      .step_len_i  (step_len),
      .hold_len_i  (hold_len),
      .duty_o      (duty[g*DW +: DW]),
      .busy_o      (busy[g]),
      .done_o      (done[g])
    );
  end

`ifdef BREATH_PWM_EN
  logic [DW-1:0]  pcnt_q, pcnt_d;
  logic [NCH-1:0] pwm_q, pwm_d;

  always_comb begin
    pcnt_d = (pcnt_q == DW'(MAX_DUTY - 1)) ? '0 : pcnt_q + DW'(1);
    pwm_d  = '0;
    for (int i = 0; i < NCH; i++) begin
      pwm_d[i] = duty[i*DW +: DW] > pcnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt_q <= '0;
      pwm_q  <= '0;
    end else begin
      pcnt_q <= pcnt_d;
      pwm_q  <= pwm_d;
    end
  end

  assign pwm = pwm_q;
`else
  assign pwm = '0;
`endif

endmodule

// File: tb/tb_breath_ramp_multi.sv
// Directed bench for breath_ramp_multi: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them against the DUT.
module tb_breath_ramp_multi;

  localparam int NCH    = 4;
  localparam int DW     = 4;
  localparam int MAXD   = 10;
  localparam int STEP_W = 10;
  localparam int HOLD_W = 12;

  localparam int F_DUTY = 0;
  localparam int F_BUSY = 1;
  localparam int F_DONE = 2;
  localparam int F_PWM  = 3;
  localparam int F_DCNT = 4;
  localparam int F_PWIN = 5;

`ifdef BREATH_PWM_EN
  localparam int PW0 = 3;
  localparam int PW2 = 10;
`else
  localparam int PW0 = 0;
  localparam int PW2 = 0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NCH-1:0]    start = '0;
  logic [NCH-1:0]    stop = '0;
  logic              loop_mode = 1'b0;
  logic [STEP_W-1:0] step_len = '0;
  logic [HOLD_W-1:0] hold_len = '0;
  logic [NCH*DW-1:0] duty;
  logic [NCH-1:0]    busy, done, pwm;

  breath_ramp_multi #(
    .NCH(NCH), .DW(DW), .MAX_DUTY(MAXD), .STEP_W(STEP_W), .HOLD_W(HOLD_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .loop_mode (loop_mode),
    .step_len  (step_len),
    .hold_len  (hold_len),
    .duty      (duty),
    .busy      (busy),
    .done      (done),
    .pwm       (pwm)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int at;
    int ch;
    int fld;
    int val;
  } exp_t;

  exp_t       sbq[$];
  int         n_chk = 0;
  int         n_pass = 0;
  int         done_cnt[NCH];
  logic [9:0] pwm_hist[NCH];

  task automatic ex(input int at, input int ch, input int fld, input int val);
    exp_t e;
    int   idx;
    e.at = at; e.ch = ch; e.fld = fld; e.val = val;
    idx = sbq.size();
    while (idx > 0 && sbq[idx-1].at > at) idx--;
    sbq.insert(idx, e);
  endtask

  function automatic logic [31:0] actual(input int ch, input int fld);
    case (fld)
      F_DUTY:  return 32'(duty[ch*DW +: DW]);
      F_BUSY:  return 32'(busy[ch]);
      F_DONE:  return 32'(done[ch]);
      F_PWM:   return 32'(pwm[ch]);
      F_DCNT:  return 32'(done_cnt[ch]);
      default: return 32'($countones(pwm_hist[ch]));
    endcase
  endfunction

  function automatic string fname(input int fld);
    case (fld)
      F_DUTY:  return "duty";
      F_BUSY:  return "busy";
      F_DONE:  return "done";
      F_PWM:   return "pwm";
      F_DCNT:  return "done_count";
      default: return "pwm_high_in_10";
    endcase
  endfunction

  // Monitor: tracks done pulses and a 10-sample pwm history, then retires due expectations.
  initial begin
    exp_t        e;
    logic [31:0] a;
    for (int i = 0; i < NCH; i++) begin
      pwm_hist[i] = '0;
      done_cnt[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < NCH; i++) begin
        if (done[i] === 1'b1) done_cnt[i]++;
        pwm_hist[i] = {pwm_hist[i][8:0], pwm[i]};
      end
      while (sbq.size() > 0 && sbq[0].at <= cyc) begin
        e = sbq.pop_front();
        a = actual(e.ch, e.fld);
        n_chk++;
        if (a === 32'(e.val)) n_pass++;
        else $display("FAIL %s ch%0d cyc=%0d got=%0d expected=%0d",
                      fname(e.fld), e.ch, cyc, a, e.val);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  initial begin
    int e0, e1, r, s;

    // Reset state
    tick(3);
    for (int c = 0; c < NCH; c++) begin
      ex(cyc + 1, c, F_DUTY, 0);
      ex(cyc + 1, c, F_BUSY, 0);
      ex(cyc + 1, c, F_DONE, 0);
      ex(cyc + 1, c, F_PWM, 0);
    end
    tick(2);
    rst = 1'b0;
    tick(2);

    // 1: step 3, hold 5, single cycle on channel 0
    step_len = 10'd3; hold_len = 12'd5; loop_mode = 1'b0;
    start[0] = 1'b1;
    e0 = cyc + 1;
    ex(e0, 0, F_BUSY, 1);      ex(e0, 0, F_DUTY, 0);
    ex(e0 + 2, 0, F_DUTY, 0);  ex(e0 + 3, 0, F_DUTY, 1);
    ex(e0 + 29, 0, F_DUTY, 9); ex(e0 + 30, 0, F_DUTY, 10);
    ex(e0 + 34, 0, F_DUTY, 10); ex(e0 + 38, 0, F_DUTY, 9);
    ex(e0 + 64, 0, F_DONE, 0); ex(e0 + 64, 0, F_BUSY, 1);
    ex(e0 + 65, 0, F_DONE, 1); ex(e0 + 65, 0, F_BUSY, 0);
    ex(e0 + 65, 0, F_DUTY, 0); ex(e0 + 66, 0, F_DONE, 0);
    for (int c = 1; c < NCH; c++) begin
      ex(e0 + 30, c, F_DUTY, 0);
      ex(e0 + 30, c, F_BUSY, 0);
    end
    ex(e0 + 70, 0, F_DCNT, 1);
    tick(1);
    start[0] = 1'b0;
    wait_to(e0 + 72);

    // 2: zero lengths behave as one cycle
    step_len = '0; hold_len = '0;
    start[0] = 1'b1;
    e0 = cyc + 1;
    ex(e0 + 1, 0, F_DUTY, 1);   ex(e0 + 5, 0, F_DUTY, 5);
    ex(e0 + 10, 0, F_DUTY, 10); ex(e0 + 11, 0, F_DUTY, 10);
    ex(e0 + 12, 0, F_DUTY, 9);  ex(e0 + 20, 0, F_DUTY, 1);
    ex(e0 + 20, 0, F_BUSY, 1);  ex(e0 + 21, 0, F_DONE, 1);
    ex(e0 + 21, 0, F_BUSY, 0);  ex(e0 + 25, 0, F_DCNT, 2);
    tick(1);
    start[0] = 1'b0;
    wait_to(e0 + 26);

    // 3: loop mode on channel 2, cleared during the second rise
    step_len = 10'd2; hold_len = 12'd1; loop_mode = 1'b1;
    start[2] = 1'b1;
    e0 = cyc + 1;
    ex(e0 + 2, 2, F_DUTY, 1);   ex(e0 + 20, 2, F_DUTY, 10);
    ex(e0 + 21, 2, F_DUTY, 10); ex(e0 + 23, 2, F_DUTY, 9);
    ex(e0 + 41, 2, F_DUTY, 0);  ex(e0 + 41, 2, F_BUSY, 1);
    ex(e0 + 41, 2, F_DONE, 0);  ex(e0 + 42, 2, F_DUTY, 0);
    ex(e0 + 43, 2, F_DUTY, 1);  ex(e0 + 81, 2, F_DUTY, 1);
    ex(e0 + 82, 2, F_DONE, 1);  ex(e0 + 82, 2, F_BUSY, 0);
    ex(e0 + 86, 2, F_DCNT, 1);
    tick(1);
    start[2] = 1'b0;
    wait_to(e0 + 44);
    loop_mode = 1'b0;
    wait_to(e0 + 88);

    // 4: stop at duty 6, then stop together with a start edge
    step_len = 10'd3; hold_len = 12'd5;
    start[1] = 1'b1;
    e0 = cyc + 1;
    ex(e0 + 18, 1, F_DUTY, 6); ex(e0 + 19, 1, F_DUTY, 0);
    ex(e0 + 19, 1, F_BUSY, 0); ex(e0 + 19, 1, F_DONE, 0);
    ex(e0 + 22, 1, F_DUTY, 0); ex(e0 + 22, 1, F_BUSY, 0);
    tick(1);
    start[1] = 1'b0;
    wait_to(e0 + 18);
    stop[1] = 1'b1;
    tick(1);
    stop[1] = 1'b0;
    wait_to(e0 + 25);
    stop[1] = 1'b1; start[1] = 1'b1;
    e1 = cyc + 1;
    ex(e1, 1, F_BUSY, 0);     ex(e1, 1, F_DUTY, 0);
    ex(e1 + 4, 1, F_BUSY, 0); ex(e1 + 4, 1, F_DUTY, 0);
    ex(e1 + 6, 1, F_DCNT, 0);
    tick(1);
    stop[1] = 1'b0;
    tick(7);
    start[1] = 1'b0;

    // 5: retrigger ignored, async reset mid-hold, start held across reset release
    start[3] = 1'b1;
    e0 = cyc + 1;
    ex(e0 + 3, 3, F_DUTY, 1);   ex(e0 + 12, 3, F_DUTY, 4);
    ex(e0 + 14, 3, F_DUTY, 4);  ex(e0 + 15, 3, F_DUTY, 5);
    ex(e0 + 30, 3, F_DUTY, 10); ex(e0 + 31, 3, F_DUTY, 10);
    ex(e0 + 32, 3, F_DUTY, 0);  ex(e0 + 32, 3, F_BUSY, 0);
    ex(e0 + 32, 3, F_DONE, 0);
    tick(1);
    start[3] = 1'b0;
    wait_to(e0 + 10);
    start[3] = 1'b1;
    tick(1);
    start[3] = 1'b0;
    wait_to(e0 + 31);
    @(posedge clk);
    #2;
    rst = 1'b1;
    start[3] = 1'b1;
    tick(3);
    rst = 1'b0;
    r = cyc;
    ex(r + 1, 3, F_BUSY, 1);  ex(r + 1, 3, F_DUTY, 0);
    ex(r + 4, 3, F_DUTY, 1);  ex(r + 65, 3, F_DONE, 0);
    ex(r + 66, 3, F_DONE, 1); ex(r + 66, 3, F_BUSY, 0);
    ex(r + 70, 3, F_DCNT, 1); ex(r + 70, 1, F_DCNT, 0);
    wait_to(r + 72);
    start[3] = 1'b0;

    // 6: pwm with duty0 parked at 3, duty1 at 0, duty2 at peak
    step_len = '0; hold_len = 12'd4000;
    start[2] = 1'b1;
    s = cyc + 1;
    wait_to(s + 11);
    start[2] = 1'b0;
    step_len = 10'd1023;
    start[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ex(s + 3200 + 100 * k, 0, F_DUTY, 3);
      ex(s + 3200 + 100 * k, 2, F_DUTY, 10);
      ex(s + 3200 + 100 * k, 1, F_DUTY, 0);
      ex(s + 3200 + 100 * k, 0, F_PWIN, PW0);
      ex(s + 3200 + 100 * k, 1, F_PWIN, 0);
      ex(s + 3200 + 100 * k, 2, F_PWIN, PW2);
      ex(s + 3200 + 100 * k, 3, F_PWIN, 0);
    end
    tick(1);
    start[0] = 1'b0;
    wait_to(s + 3402);
    stop = '1;
    ex(cyc + 1, 0, F_BUSY, 0); ex(cyc + 1, 2, F_BUSY, 0);
    ex(cyc + 1, 0, F_DUTY, 0); ex(cyc + 1, 2, F_DUTY, 0);
    ex(cyc + 3, 0, F_DCNT, 2); ex(cyc + 3, 2, F_DCNT, 1);
    tick(1);
    stop = '0;
    tick(5);

    if (sbq.size() > 0) begin
      $display("FAIL scoreboard_drain leftover=%0d expected=0", sbq.size());
      n_chk += sbq.size();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/breath_ramp_multi.md
Name: breath_ramp_multi

Overview:
Multi-channel LED "breathing" generator, the parametrised successor to the single-channel duty ramp. Each channel, on a start rising edge, ramps its duty from 0 up to MAX_DUTY, holds at the peak, then ramps back down to 0. Step length and hold length are runtime inputs; a runtime loop mode repeats the cycle continuously. Channels are independent and share one free-running PWM counter that drives per-channel pwm outputs.

Parameters:
NCH, 4, number of independent channels
DW, 4, duty width in bits; 1 <= MAX_DUTY <= 2^DW-1
MAX_DUTY, 10, peak duty value and PWM period in clk cycles
STEP_W, 10, width of step_len
HOLD_W, 12, width of hold_len

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  NCH  per-channel start level; a rising edge launches that channel
stop  in  NCH  per-channel synchronous abort
loop_mode  in  1  shared; 1 = restart the rise after reaching bottom instead of finishing
step_len  in  STEP_W  clk cycles per duty step; value 0 is treated as 1
hold_len  in  HOLD_W  clk cycles spent at peak; value 0 is treated as 1
duty  out  NCH*DW  current duty, channel i in bits [i*DW +: DW]
busy  out  NCH  channel active (any state other than IDLE)
done  out  NCH  one-cycle pulse when a non-loop cycle completes
pwm  out  NCH  PWM output per channel

Behaviour:
- Reset state, all registers: duty=0, busy=0, done=0, pwm=0, state=IDLE, start_r=0, tmr=0, pcnt=0.
- Edge detect: edge[i] = start[i] & ~start_r[i]; start_r[i] is registered every cycle. A start held high through reset release counts as an edge on the first clock.
- Per-channel FSM states are IDLE, RISE, HOLD, FALL. Each channel has a down-counter tmr. A tick occurs on any cycle where tmr==0 in RISE, HOLD or FALL.
- IDLE, on edge: go to RISE; busy=1; tmr=max(step_len,1)-1. The duty and busy change at the same clock edge that samples the edge.
- RISE, on tick: duty+=1; tmr reloads from step_len. If the new duty equals MAX_DUTY, go to HOLD with tmr=max(hold_len,1)-1.
- HOLD, on tick: go to FALL; tmr reloads from step_len.
- FALL, on tick: duty-=1.
  - If the new duty equals 0 and loop_mode=1: go to RISE, reload tmr, busy stays 1.
  - If the new duty equals 0 and loop_mode=0: go to IDLE, busy=0, done=1 for one cycle.
- Otherwise in every active state: tmr-=1.
- Timing: duty first reaches 1 exactly step cycles after busy rises. A non-loop cycle takes 2*MAX_DUTY*step + hold cycles from busy rise to done.
- Input sampling: step_len and hold_len are sampled only at tmr reload. loop_mode is sampled only at the bottom of FALL.
- start edge while busy is ignored; there is no retrigger.
- stop[i]=1 in any state: next cycle IDLE, duty=0, busy=0, tmr=0, no done pulse.
- stop and edge on the same cycle: stop wins and the channel stays IDLE.
- Asserting rst mid-ramp immediately forces the reset values.
- duty never exceeds MAX_DUTY and never wraps below 0.

Optional Feature:
Macro BREATH_PWM_EN.
- Defined: a shared counter pcnt counts 0..MAX_DUTY-1 and wraps to 0. pwm[i] is registered as (duty[i] > pcnt), so duty=0 keeps pwm low and duty=MAX_DUTY keeps it high.
- Not defined: pcnt is absent and pwm is tied to 0. Ports are unchanged.

Decomposition:
- Package breath_pkg holds the state encoding (IDLE=2'd0, RISE=2'd1, HOLD=2'd2, FALL=2'd3) and the default parameter constants.
- Sub-module breath_chan contains one channel: edge detect, FSM, tmr and duty register. It is instantiated NCH times.
- The top level holds the shared pcnt and pwm compare, and packs duty.

Test Plan:
1. step_len=3, hold_len=5, loop_mode=0, start[0] edge:
   - busy[0]=1 on the edge clock;
   - duty0=1 3 cycles later and duty0=10 at +30;
   - done[0] pulses at +65 and busy[0]=0 there;
   - other channels stay 0.
2. step_len=0, hold_len=0: behaves as 1 and 1. duty changes every cycle; done at +21.
3. loop_mode=1: after duty reaches 0 it goes directly back to 1 step later; no done, busy stays 1. Clear loop_mode mid-RISE: done fires at the end of that cycle.
4. stop[1] at duty=6 in RISE -> duty1=0 and busy1=0 next cycle, no done. Repeat with stop and start edge in the same cycle -> stays IDLE.
5. Second start edge while busy, and rst asserted mid-HOLD:
   - the edge is ignored with unchanged timing;
   - rst forces all outputs to 0 asynchronously;
   - a start held high across reset release relaunches.
6. BREATH_PWM_EN defined, duty0 held at 3, duty1=0, duty2=10:
   - pwm0 high 3 of every 10 cycles;
   - pwm1 constant 0 and pwm2 constant 1.
   Undefined: all pwm are 0.
